// File: rtl/bcd_sw_pkg.sv
// Shared types and constants for the BCD stopwatch controller and its digit cells.
package bcd_sw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } sw_state_t;

    localparam int             BCD_W   = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_sw_digit.sv
// One decimal digit of the stopwatch count; At9 feeds the combinational carry chain.
module bcd_sw_digit
    import bcd_sw_pkg::*;
(
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Clr,
    input  logic             Inc,
    output logic [BCD_W-1:0] q,
    output logic             At9
);

    // Digit register: counts 0..9 on Inc and wraps back to 0 after 9
    always_ff @(posedge Clk) begin
        if (Rst || Clr) begin
            q <= '0;
        end else if (Inc) begin
            q <= (q == BCD_MAX) ? '0 : q + BCD_W'(1);
        end
    end

    assign At9 = (q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Multi-digit BCD stopwatch: run/pause/lap sequencing, tick prescaler and digit chain.
// Optional lap readout is compiled in when the macro BCD_SW_LAP_EN is defined.
module bcd_stopwatch_ctrl
    import bcd_sw_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50000
)
(
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    Start_Stop,
    input  logic                    Clear,
    input  logic                    Lap,
    output logic [BCD_W*DIGITS-1:0] Cnt,
    output logic [BCD_W*DIGITS-1:0] Disp,
    output logic                    Running,
    output logic                    Ovf
);

    localparam int               PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    sw_state_t        state_q;
    sw_state_t        state_d;
    logic [PRE_W-1:0] presc_q;
    logic             tick;
    logic             lap_req;
    logic [DIGITS-1:0] at9;

`ifdef BCD_SW_LAP_EN
    assign lap_req = Lap;
`else
    // Without the lap feature the Lap button has no effect at all
    assign lap_req = Lap & 1'b0;
`endif

    // Controller state register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: Clear beats Start_Stop, which beats Lap
    always_comb begin
        state_d = state_q;
        if (Clear) begin
            state_d = IDLE;
        end else if (Start_Stop) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                LAP:     state_d = PAUSE;
                default: state_d = IDLE;
            endcase
        end else if (lap_req) begin
            case (state_q)
                RUN:     state_d = LAP;
                LAP:     state_d = RUN;
                default: state_d = state_q;
            endcase
        end
    end

    assign Running = (state_q == RUN) || (state_q == LAP);
    assign tick    = Running && (presc_q == PRE_LAST);

    // Prescaler: advances only while running and holds through a pause
    always_ff @(posedge Clk) begin
        if (Rst || Clear) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else if (Running) begin
            presc_q <= presc_q + PRE_W'(1);
        end
    end

    // Digit chain: digit k advances on a tick when every lower digit reads 9
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic inc;
        if (k == 0) begin : g_lsd
            assign inc = tick;
        end else begin : g_upper
            assign inc = tick && (&at9[k-1:0]);
        end

        bcd_sw_digit u_digit (
            .Clk (Clk),
            .Rst (Rst),
            .Clr (Clear),
            .Inc (inc),
            .q   (Cnt[BCD_W*k +: BCD_W]),
            .At9 (at9[k])
        );
    end

    // Sticky overflow flag, set when a tick wraps all-9s back to zero
    always_ff @(posedge Clk) begin
        if (Rst || Clear) begin
            Ovf <= 1'b0;
        end else if (tick && (&at9)) begin
            Ovf <= 1'b1;
        end
    end

`ifdef BCD_SW_LAP_EN
    logic [BCD_W*DIGITS-1:0] lap_q;

    // Lap register: captures the pre-tick count when a lap freezes the display
    always_ff @(posedge Clk) begin
        if (Rst || Clear) begin
            lap_q <= '0;
        end else if ((state_q == RUN) && !Start_Stop && Lap) begin
            lap_q <= Cnt;
        end
    end

    assign Disp = (state_q == LAP) ? lap_q : Cnt;
`else
    assign Disp = Cnt;
`endif

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Self-checking bench for bcd_stopwatch_ctrl (DIGITS=2, TICK_DIV=4).
// Lap expectations follow the BCD_SW_LAP_EN macro, matching the DUT build.
module tb_bcd_stopwatch_ctrl;

    localparam int DIGITS   = 2;
    localparam int TICK_DIV = 4;
    localparam int MAXCOUNT = 100;

`ifdef BCD_SW_LAP_EN
    localparam bit LAP_ON = 1'b1;
`else
    localparam bit LAP_ON = 1'b0;
`endif

    logic                  Clk;
    logic                  Rst;
    logic                  Start_Stop;
    logic                  Clear;
    logic                  Lap;
    logic [4*DIGITS-1:0]   Cnt;
    logic [4*DIGITS-1:0]   Disp;
    logic                  Running;
    logic                  Ovf;

    int vectors    = 0;
    int miscompares = 0;
    bit checkEn    = 1'b0;

    // Reference model state, in plain integers
    int mCount  = 0;
    int mPhase  = 0;
    int mLapVal = 0;
    bit mRun    = 1'b0;
    bit mFrozen = 1'b0;
    bit mOvf    = 1'b0;

    bcd_stopwatch_ctrl #(
        .DIGITS   (DIGITS),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Start_Stop (Start_Stop),
        .Clear      (Clear),
        .Lap        (Lap),
        .Cnt        (Cnt),
        .Disp       (Disp),
        .Running    (Running),
        .Ovf        (Ovf)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [4*DIGITS-1:0] toBcd(input int value);
        logic [4*DIGITS-1:0] r;
        int v;
        r = '0;
        v = value;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Model update: stopwatch behaviour expressed as integer time keeping
    always @(posedge Clk) begin
        int prevCount;
        prevCount = mCount;
        if (Rst || Clear) begin
            mCount = 0; mPhase = 0; mLapVal = 0;
            mRun = 0; mFrozen = 0; mOvf = 0;
        end else begin
            if (mRun) begin
                if (mPhase == TICK_DIV - 1) begin
                    mPhase = 0;
                    mCount = mCount + 1;
                    if (mCount == MAXCOUNT) begin
                        mCount = 0;
                        mOvf = 1;
                    end
                end else begin
                    mPhase = mPhase + 1;
                end
            end
            if (Start_Stop) begin
                mRun = !mRun;
                mFrozen = 0;
            end else if (Lap && LAP_ON && mRun) begin
                if (!mFrozen) begin
                    mFrozen = 1;
                    mLapVal = prevCount;
                end else begin
                    mFrozen = 0;
                end
            end
        end
    end

    // Every-cycle compare against the model, away from the active edge
    always @(negedge Clk) begin
        logic [4*DIGITS-1:0] eCnt, eDisp;
        if (checkEn) begin
            eCnt  = toBcd(mCount);
            eDisp = mFrozen ? toBcd(mLapVal) : toBcd(mCount);
            vectors++;
            if (Cnt !== eCnt || Disp !== eDisp || Running !== mRun || Ovf !== mOvf) begin
                miscompares++;
                $display("[TB] FAIL model t=%0t: Cnt=%h/%h Disp=%h/%h Running=%b/%b Ovf=%b/%b (got/expected)",
                         $time, Cnt, eCnt, Disp, eDisp, Running, mRun, Ovf, mOvf);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive one clock of pulses, then drop them back to zero
    task automatic applyStimulus(input bit ss, input bit clr, input bit lap, input bit rst);
        Start_Stop = ss;
        Clear      = clr;
        Lap        = lap;
        Rst        = rst;
        @(negedge Clk);
        Start_Stop = 1'b0;
        Clear      = 1'b0;
        Lap        = 1'b0;
        Rst        = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    initial begin
        Rst = 1'b1; Start_Stop = 1'b0; Clear = 1'b0; Lap = 1'b0;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        checkEn = 1'b1;
        checkOutput("reset Cnt", 32'(Cnt), 32'h00);
        checkOutput("reset Disp", 32'(Disp), 32'h00);
        checkOutput("reset Running", 32'(Running), 32'h0);
        checkOutput("reset Ovf", 32'(Ovf), 32'h0);

        // Start and let the ones digit carry into the tens digit
        applyStimulus(1, 0, 0, 0);
        idle(36);
        checkOutput("count 09", 32'(Cnt), 32'h09);
        idle(4);
        checkOutput("carry 10", 32'(Cnt), 32'h10);
        checkOutput("running", 32'(Running), 32'h1);

        // Run up to 99, then wrap and set the sticky overflow
        idle(356);
        checkOutput("count 99", 32'(Cnt), 32'h99);
        checkOutput("no ovf at 99", 32'(Ovf), 32'h0);
        idle(4);
        checkOutput("wrap 00", 32'(Cnt), 32'h00);
        checkOutput("ovf set", 32'(Ovf), 32'h1);
        idle(8);
        checkOutput("ovf sticky", 32'(Ovf), 32'h1);
        checkOutput("count 02", 32'(Cnt), 32'h02);

        // Clear, restart, and lap at 12
        applyStimulus(0, 1, 0, 0);
        checkOutput("clear ovf", 32'(Ovf), 32'h0);
        applyStimulus(1, 0, 0, 0);
        idle(48);
        checkOutput("count 12", 32'(Cnt), 32'h12);
        applyStimulus(0, 0, 1, 0);
        idle(11);
        checkOutput("count 15", 32'(Cnt), 32'h15);
        checkOutput("lap disp", 32'(Disp), LAP_ON ? 32'h12 : 32'h15);
        applyStimulus(0, 0, 1, 0);
        checkOutput("lap release", 32'(Disp), 32'h15);

        // Pause two cycles into the tick period, resume, expect tick 2 cycles later
        applyStimulus(1, 0, 0, 0);
        idle(10);
        checkOutput("paused count", 32'(Cnt), 32'h15);
        checkOutput("paused running", 32'(Running), 32'h0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("resume edge", 32'(Cnt), 32'h15);
        idle(1);
        checkOutput("resume +1", 32'(Cnt), 32'h15);
        idle(1);
        checkOutput("resume +2", 32'(Cnt), 32'h16);

        // Clear beats Start_Stop in the same cycle
        applyStimulus(1, 1, 0, 0);
        checkOutput("clr+ss Cnt", 32'(Cnt), 32'h00);
        checkOutput("clr+ss Running", 32'(Running), 32'h0);

        // Randomized pulses, all checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 149) == 0),
                          ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 499) == 0));
        end

        checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
